// File: rtl/demux_tree_if.sv
// Producer/consumer bundle for demux_tree: one input stream fanning out to N_OUT lanes.
// The testbench or producer uses the master modport, and the demux uses the slave modport.
interface demux_tree_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4
);
    localparam int SEL_W = $clog2(N_OUT);

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic                    err_sel;
    logic [7:0]              drop_cnt;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, err_sel, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, err_sel, drop_cnt
    );
endinterface

// File: rtl/demux_tree.sv
// 1-to-N registered demux: each beat is routed by in_sel into a per-lane 2-entry FIFO.
// Optional DEMUX_CAL_EN stores ((in_data << 2) + 1) instead of the raw payload.
module demux_lane #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              rdy,
    input  logic [DATA_W-1:0] din,
    output logic              vld,
    output logic              full,
    output logic [DATA_W-1:0] dout
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} lane_st_t;

    lane_st_t          st, st_n;
    logic [DATA_W-1:0] head, head_n, tail, tail_n;
    logic              pop;

    assign vld  = (st != EMPTY);
    assign full = (st == FULL);
    assign dout = head;
    assign pop  = vld & rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            st   <= st_n;
            head <= head_n;
            tail <= tail_n;
        end
    end

    // A push into FULL cannot occur: in_ready masks the lane while it is full.
    always_comb begin
        st_n   = st;
        head_n = head;
        tail_n = tail;
        case (st)
            EMPTY: if (push) begin
                st_n   = ONE;
                head_n = din;
            end
            ONE: begin
                if (push && pop) begin
                    head_n = din;
                end else if (push) begin
                    st_n   = FULL;
                    tail_n = din;
                end else if (pop) begin
                    st_n = EMPTY;
                end
            end
            FULL: if (pop) begin
                st_n   = ONE;
                head_n = tail;
            end
            default: st_n = EMPTY;
        endcase
    end
endmodule

module demux_tree #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4
) (
    input logic         clk,
    input logic         rst_n,
    demux_tree_if.slave bus
);
    localparam int             SEL_W = $clog2(N_OUT);
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_OUT);

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t                          req;
    logic [DATA_W-1:0]              payload;
    logic                           sel_oob, full_sel, accept;
    logic [N_OUT-1:0]               lane_full, lane_vld, push;
    logic [N_OUT-1:0][DATA_W-1:0]   lane_data;
    logic                           err_q;
    logic [7:0]                     drop_q;

    assign req = '{sel: bus.in_sel, data: bus.in_data};

`ifdef DEMUX_CAL_EN
    // The two low bits of (d << 2) are zero, so the +1 only sets bit 0.
    assign payload = {req.data[DATA_W-3:0], 2'b01};
`else
    assign payload = req.data;
`endif

    assign sel_oob = ({1'b0, req.sel} >= N_LIM);

    always_comb begin
        full_sel = 1'b0;
        for (int i = 0; i < N_OUT; i++)
            if (req.sel == SEL_W'(i)) full_sel = lane_full[i];
    end

    // in_ready depends only on the selected lane state and never on in_valid.
    assign bus.in_ready = sel_oob | ~full_sel;
    assign accept       = bus.in_valid & bus.in_ready;

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_lane
            assign push[g] = accept & ~sel_oob & (req.sel == SEL_W'(g));
            demux_lane #(.DATA_W(DATA_W)) u_lane (
                .clk  (clk),
                .rst_n(rst_n),
                .push (push[g]),
                .rdy  (bus.out_ready[g]),
                .din  (payload),
                .vld  (lane_vld[g]),
                .full (lane_full[g]),
                .dout (lane_data[g])
            );
        end
    endgenerate

    assign bus.out_valid = lane_vld;
    assign bus.out_data  = lane_data;

    // Out-of-range beats are swallowed: one-cycle error pulse plus a saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            err_q <= accept & sel_oob;
            if (accept && sel_oob && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.err_sel  = err_q;
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_demux_tree.sv
// Self-checking bench for demux_tree: N_OUT=4 instance driven from a vector table with a
// per-lane scoreboard, plus an N_OUT=3 instance for out-of-range select handling.
module tb_demux_tree;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    demux_tree_if #(.DATA_W(8), .N_OUT(4)) if4 ();
    demux_tree_if #(.DATA_W(8), .N_OUT(3)) if3 ();

    demux_tree #(.DATA_W(8), .N_OUT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    demux_tree #(.DATA_W(8), .N_OUT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] stored(input logic [7:0] d);
`ifdef DEMUX_CAL_EN
        logic [9:0] w;
        w = {2'b00, d} * 10'd4 + 10'd1;
        return w[7:0];
`else
        return d;
`endif
    endfunction

    // Scoreboard for the 4-lane instance: expected lane contents in FIFO order.
    logic [7:0] q4 [4][$];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) q4[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("lane%0d_valid", i), 32'(if4.out_valid[i]), 32'(q4[i].size() != 0));
                if (if4.out_valid[i] && q4[i].size() != 0)
                    chk($sformatf("lane%0d_data", i), 32'(if4.out_data[i*8 +: 8]), 32'(q4[i][0]));
            end
            chk("in_ready4", 32'(if4.in_ready), 32'(q4[if4.in_sel].size() < 2));
            for (int i = 0; i < 4; i++)
                if (if4.out_valid[i] && if4.out_ready[i] && q4[i].size() != 0) void'(q4[i].pop_front());
            if (if4.in_valid && if4.in_ready) q4[if4.in_sel].push_back(stored(if4.in_data));
        end
    end

    // Model for the 3-lane instance: lane occupancy (consumers never ready) and drop logic.
    int         cnt3 [3];
    logic       exp_err3;
    logic [7:0] exp_drop3;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt3[i] = 0;
            exp_err3  = 1'b0;
            exp_drop3 = 8'd0;
        end else begin
            chk("err_sel3", 32'(if3.err_sel), 32'(exp_err3));
            chk("drop_cnt3", 32'(if3.drop_cnt), 32'(exp_drop3));
            chk("out_valid3", 32'(if3.out_valid), 32'({cnt3[2] != 0, cnt3[1] != 0, cnt3[0] != 0}));
            chk("in_ready3", 32'(if3.in_ready), 32'((if3.in_sel >= 2'd3) || (cnt3[if3.in_sel] < 2)));
            exp_err3 = 1'b0;
            if (if3.in_valid && if3.in_ready) begin
                if (if3.in_sel >= 2'd3) begin
                    exp_err3 = 1'b1;
                    if (exp_drop3 != 8'hFF) exp_drop3 = exp_drop3 + 8'd1;
                end else begin
                    cnt3[if3.in_sel] = cnt3[if3.in_sel] + 1;
                end
            end
        end
    end

    typedef struct {
        logic       vld;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] rdy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t vt [20];

    task automatic drive4(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        if4.in_valid  = v;
        if4.in_sel    = s;
        if4.in_data   = d;
        if4.out_ready = r;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ov4"},   32'(if4.out_valid), 32'h0);
        chk({tag, "_od4"},   if4.out_data,       32'h0);
        chk({tag, "_err4"},  32'(if4.err_sel),   32'h0);
        chk({tag, "_drop4"}, 32'(if4.drop_cnt),  32'h0);
        chk({tag, "_ov3"},   32'(if3.out_valid), 32'h0);
        chk({tag, "_od3"},   32'(if3.out_data),  32'h0);
        chk({tag, "_err3"},  32'(if3.err_sel),   32'h0);
        chk({tag, "_drop3"}, 32'(if3.drop_cnt),  32'h0);
    endtask

    initial begin
        // row = {vld, sel, data, out_ready, in_ready now, out_valid now}
        vt[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0000};
        vt[1]  = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0100};
        vt[2]  = '{1'b0, 2'd0, 8'h00, 4'b0100, 1'b1, 4'b0100};
        vt[3]  = '{1'b1, 2'd1, 8'h11, 4'b0000, 1'b1, 4'b0000};
        vt[4]  = '{1'b1, 2'd1, 8'h22, 4'b0000, 1'b1, 4'b0010};
        vt[5]  = '{1'b1, 2'd1, 8'h33, 4'b0000, 1'b0, 4'b0010};
        vt[6]  = '{1'b1, 2'd1, 8'h33, 4'b0010, 1'b0, 4'b0010};
        vt[7]  = '{1'b1, 2'd1, 8'h33, 4'b0010, 1'b1, 4'b0010};
        vt[8]  = '{1'b0, 2'd1, 8'h00, 4'b0010, 1'b1, 4'b0010};
        vt[9]  = '{1'b1, 2'd0, 8'h01, 4'b0000, 1'b1, 4'b0000};
        vt[10] = '{1'b1, 2'd0, 8'h02, 4'b0000, 1'b1, 4'b0001};
        vt[11] = '{1'b1, 2'd0, 8'h03, 4'b0000, 1'b0, 4'b0001};
        vt[12] = '{1'b1, 2'd3, 8'h7E, 4'b0000, 1'b1, 4'b0001};
        vt[13] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b1001};
        vt[14] = '{1'b1, 2'd1, 8'h40, 4'b0000, 1'b1, 4'b1001};
        vt[15] = '{1'b1, 2'd1, 8'h44, 4'b0010, 1'b1, 4'b1011};
        vt[16] = '{1'b0, 2'd1, 8'h00, 4'b0000, 1'b1, 4'b1011};
        vt[17] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 4'b1011};
        vt[18] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0001};
        vt[19] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000};

        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        if3.in_valid  = 1'b0;
        if3.in_sel    = 2'd0;
        if3.in_data   = 8'h00;
        if3.out_ready = 3'b000;

        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        #1 rst_n = 1'b1;

        // Routing, back-pressure, lane independence and push+pop on a one-entry lane.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            drive4(vt[i].vld, vt[i].sel, vt[i].data, vt[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(if4.in_ready), 32'(vt[i].exp_rdy));
            chk($sformatf("vec%0d_out_valid", i), 32'(if4.out_valid), 32'(vt[i].exp_ov));
        end
        @(posedge clk); #1 drive4(1'b0, 2'd0, 8'h00, 4'b0000);

        // Out-of-range select on the 3-lane instance.
        @(posedge clk); #1;
        if3.in_valid = 1'b1; if3.in_sel = 2'd0; if3.in_data = 8'h5A;
        @(posedge clk); #1;
        if3.in_sel = 2'd3; if3.in_data = 8'h99;
        @(negedge clk);
        chk("oob_in_ready", 32'(if3.in_ready), 32'h1);
        @(posedge clk); #1 if3.in_valid = 1'b0;
        @(negedge clk);
        chk("oob_err_pulse", 32'(if3.err_sel), 32'h1);
        chk("oob_drop_one", 32'(if3.drop_cnt), 32'h1);
        chk("oob_ov_hold", 32'(if3.out_valid), 32'h1);
        @(negedge clk);
        chk("oob_err_clear", 32'(if3.err_sel), 32'h0);
        @(posedge clk); #1;
        if3.in_valid = 1'b1; if3.in_sel = 2'd3;
        repeat (256) @(posedge clk);
        #1 if3.in_valid = 1'b0;
        @(negedge clk);
        chk("drop_saturate", 32'(if3.drop_cnt), 32'hFF);
        chk("err_last_beat", 32'(if3.err_sel), 32'h1);
        @(negedge clk);
        chk("drop_hold", 32'(if3.drop_cnt), 32'hFF);

        // Stored-payload transform, then reset asserted in the middle of a burst.
        @(posedge clk); #1 drive4(1'b1, 2'd0, 8'h41, 4'b0000);
        @(posedge clk); #1 drive4(1'b1, 2'd1, 8'h52, 4'b0000);
        @(negedge clk);
`ifdef DEMUX_CAL_EN
        chk("cal_lane0", 32'(if4.out_data[7:0]), 32'h05);
`else
        chk("raw_lane0", 32'(if4.out_data[7:0]), 32'h41);
`endif
        @(posedge clk); #1 drive4(1'b1, 2'd2, 8'h63, 4'b0000);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Lane works again after reset.
        @(posedge clk); #1 drive4(1'b1, 2'd3, 8'hC3, 4'b0000);
        @(posedge clk); #1 drive4(1'b0, 2'd0, 8'h00, 4'b1000);
        @(negedge clk);
        chk("post_reset_ov", 32'(if4.out_valid), 32'h8);
        @(posedge clk); #1 drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        @(negedge clk);
        chk("post_reset_drain", 32'(if4.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
